dcr_chain_programmer: RTL and testbench

Sequencer that loads the digital control register chain over its serial interface. It takes a parallel configuration word and bit-bangs it into the chain's `dataIn`/`clk` pins from the fast system clock, at a programmable rate. Optionally it reads the word back through the chain's `dataOut` and flags mismatches. It sits between the host register file and the chip's control shift-register pins.

---
 rtl/dcr_chain_programmer.sv | 205 ++++++++++++++++++++
 tb/tb_dcr_chain_programmer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcr_chain_programmer.sv
// dcr_chain_programmer
// Bit-bangs a parallel configuration word into the digital control register
// chain (sr_clk / sr_data) at CLK_DIV system clocks per sr_clk phase.
// Optional verify pass, enabled by defining DCR_READBACK_EN: the word is
// shifted a second time while the first copy is captured from sr_dout
// into readback, and mismatch flags any difference.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; outputs parked
// SHIFT_LO | sr_clk low, sr_data presents shadow[idx]; readback sampled
// SHIFT_HI | sr_clk high, chain shifts on the rise
// FINISH   | one-cycle done pulse, mismatch resolved
module dcr_chain_programmer #(
  parameter int CHAIN_LEN = 34,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] cfg_word,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic [CHAIN_LEN-1:0] readback,
  output logic                 sr_clk,
  output logic                 sr_data,
  input  logic                 sr_dout
);

  localparam int IW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PH_LOAD  = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        idx_dec;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 sr_clk_q, sr_clk_d;
  logic                 sr_data_q, sr_data_d;
  logic                 phase_tc;
  logic                 last_pass;
  logic                 hi_end_last_bit;

  // Phase timer is a down-counter; terminal count ends the current phase.
  assign phase_tc        = (phase_q == '0);
  assign idx_dec         = idx_q - IW'(1);
  assign hi_end_last_bit = (state_q == SHIFT_HI) && phase_tc && (idx_q == '0);

`ifdef DCR_READBACK_EN
  logic                 pass_q, pass_d;
  logic [1:0]           sync_q;
  logic                 sync_dout;
  logic                 sample_en;
  logic [CHAIN_LEN-1:0] readback_q, readback_d;
  logic                 mismatch_q, mismatch_d;

  assign sync_dout = sync_q[1];
  assign last_pass = pass_q;
  // Capture at the end of LO in the verify pass: by then the previous
  // rise is 2*CLK_DIV-1 cycles old, enough for the synchronizer.
  assign sample_en = (state_q == SHIFT_LO) && phase_tc && pass_q;

  // Two-flop synchronizer for the chain output.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], sr_dout};
    end
  end

  // Pass tracking, readback capture and mismatch resolution.
  always_comb begin
    pass_d     = pass_q;
    readback_d = readback_q;
    mismatch_d = mismatch_q;
    if ((state_q == IDLE) && start) begin
      pass_d     = 1'b0;
      mismatch_d = 1'b0;
    end else if (hi_end_last_bit && !pass_q) begin
      pass_d = 1'b1;
    end else if (hi_end_last_bit && pass_q) begin
      mismatch_d = (readback_q != shadow_q);
    end
    if (sample_en) begin
      readback_d[idx_q] = sync_dout;
    end
  end

  // Readback-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q     <= 1'b0;
      readback_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      pass_q     <= pass_d;
      readback_q <= readback_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign readback = readback_q;
  assign mismatch = mismatch_q;
`else
  logic unused_sr_dout;

  assign unused_sr_dout = sr_dout;
  assign last_pass      = 1'b1;
  assign readback       = '0;
  assign mismatch       = 1'b0;
`endif

  // Sequencer next-state and registered pin values.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    sr_clk_d  = sr_clk_q;
    sr_data_d = sr_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d  = cfg_word;
          idx_d     = IDX_LAST;
          phase_d   = PH_LOAD;
          sr_clk_d  = 1'b0;
          sr_data_d = cfg_word[CHAIN_LEN-1];
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_tc) begin
          phase_d  = PH_LOAD;
          sr_clk_d = 1'b1;
          state_d  = SHIFT_HI;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      SHIFT_HI: begin
        if (!phase_tc) begin
          phase_d = phase_q - PW'(1);
        end else if (idx_q != '0) begin
          idx_d     = idx_dec;
          phase_d   = PH_LOAD;
          sr_clk_d  = 1'b0;
          sr_data_d = shadow_q[idx_dec];
          state_d   = SHIFT_LO;
        end else if (!last_pass) begin
          idx_d     = IDX_LAST;
          phase_d   = PH_LOAD;
          sr_clk_d  = 1'b0;
          sr_data_d = shadow_q[CHAIN_LEN-1];
          state_d   = SHIFT_LO;
        end else begin
          sr_clk_d = 1'b0;
          state_d  = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      phase_q   <= '0;
      sr_clk_q  <= 1'b0;
      sr_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      sr_clk_q  <= sr_clk_d;
      sr_data_q <= sr_data_d;
    end
  end

  assign busy    = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);
  assign done    = (state_q == FINISH);
  assign sr_clk  = sr_clk_q;
  assign sr_data = sr_data_q;

endmodule

// File: tb/tb_dcr_chain_programmer.sv
// Bench for dcr_chain_programmer: instance A (CLK_DIV=2) and instance B
// (CLK_DIV=3), each driving a behavioural 34-stage chain model.
// Follows DCR_READBACK_EN the same way as the design.
`timescale 1ns/1ps
module tb_dcr_chain_programmer;
  localparam int N = 34;
`ifdef DCR_READBACK_EN
  localparam int P  = 2;
  localparam bit RB = 1'b1;
`else
  localparam int P  = 1;
  localparam bit RB = 1'b0;
`endif
  localparam int TA = 2 * 2 * N * P;
  localparam int TB = 2 * 3 * N * P;

  typedef struct packed {
    logic [N-1:0] word;
    logic [31:0]  done_cyc;
    logic [N-1:0] rb;
    logic         mm;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [N-1:0] cfg_a = '0, cfg_b = '0;
  logic         busy_a, done_a, mismatch_a, sr_clk_a, sr_data_a, sr_dout_a;
  logic         busy_b, done_b, mismatch_b, sr_clk_b, sr_data_b, sr_dout_b;
  logic [N-1:0] readback_a, readback_b;
  logic         stuck = 1'b0;

  logic [N-1:0] chain_a = '0, chain_b = '0;
  int           rises_a = 0, rises_b = 0;
  int           rise0_a = 0, rise0_b = 0;
  int           done_cnt_a = 0, done_cnt_b = 0;
  int           viol_a = 0, viol_b = 0;
  logic         prev_data_a = 1'b0, prev_clk_a = 1'b0, prev_busy_a = 1'b0;
  logic         prev_data_b = 1'b0, prev_clk_b = 1'b0, prev_busy_b = 1'b0;
  logic         prev_rst = 1'b1;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  exp_t         sb_a[$];
  exp_t         sb_b[$];

  dcr_chain_programmer #(.CHAIN_LEN(N), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cfg_word(cfg_a),
    .busy(busy_a), .done(done_a), .mismatch(mismatch_a), .readback(readback_a),
    .sr_clk(sr_clk_a), .sr_data(sr_data_a), .sr_dout(sr_dout_a)
  );

  dcr_chain_programmer #(.CHAIN_LEN(N), .CLK_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cfg_word(cfg_b),
    .busy(busy_b), .done(done_b), .mismatch(mismatch_b), .readback(readback_b),
    .sr_clk(sr_clk_b), .sr_data(sr_data_b), .sr_dout(sr_dout_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain models: stage 0 nearest sr_data, output from the last stage.
  always @(posedge sr_clk_a) begin
    chain_a <= {chain_a[N-2:0], sr_data_a};
    rises_a <= rises_a + 1;
  end
  always @(posedge sr_clk_b) begin
    chain_b <= {chain_b[N-2:0], sr_data_b};
    rises_b <= rises_b + 1;
  end
  assign sr_dout_a = stuck ? 1'b0 : chain_a[N-1];
  assign sr_dout_b = chain_b[N-1];

  // Pin monitors: done pulses and sr_data moving without a falling sr_clk.
  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    if (reset === 1'b0 && prev_rst === 1'b0 && prev_busy_a === 1'b1 &&
        sr_data_a !== prev_data_a && !(prev_clk_a === 1'b1 && sr_clk_a === 1'b0))
      viol_a <= viol_a + 1;
    if (reset === 1'b0 && prev_rst === 1'b0 && prev_busy_b === 1'b1 &&
        sr_data_b !== prev_data_b && !(prev_clk_b === 1'b1 && sr_clk_b === 1'b0))
      viol_b <= viol_b + 1;
    prev_data_a <= sr_data_a; prev_clk_a <= sr_clk_a; prev_busy_a <= busy_a;
    prev_data_b <= sr_data_b; prev_clk_b <= sr_clk_b; prev_busy_b <= busy_b;
    prev_rst    <= reset;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start, push the expected result, check the E0 pins.
  task automatic do_start(input bit b, input logic [N-1:0] w);
    exp_t e;
    bit   st;
    st = stuck && !b;
    @(negedge clk);
    e.word     = w;
    e.done_cyc = cyc + 1 + (b ? TB : TA);
    e.rb       = RB ? (st ? '0 : w) : '0;
    e.mm       = RB && st && (w != '0);
    if (b) begin
      cfg_b = w; start_b = 1'b1; rise0_b = rises_b; sb_b.push_back(e);
    end else begin
      cfg_a = w; start_a = 1'b1; rise0_a = rises_a; sb_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check(b ? "e0_busy_b" : "e0_busy_a", b ? busy_b : busy_a, 1);
    check(b ? "e0_sr_clk_b" : "e0_sr_clk_a", b ? sr_clk_b : sr_clk_a, 0);
    check(b ? "e0_sr_data_b" : "e0_sr_data_a", b ? sr_data_b : sr_data_a, w[N-1]);
    if (!b) check("e0_mismatch_clear", mismatch_a, 0);
  endtask

  // Wait (bounded) for done, pop the scoreboard entry and compare.
  task automatic wait_done(input bit b);
    bit   seen;
    exp_t e;
    int   sz;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if ((b ? done_b : done_a) === 1'b1) seen = 1'b1;
    end
    check(b ? "done_seen_b" : "done_seen_a", seen, 1);
    sz = b ? sb_b.size() : sb_a.size();
    if (seen) begin
      check("sb_nonempty", sz != 0, 1);
      if (sz != 0) begin
        e = b ? sb_b.pop_front() : sb_a.pop_front();
        check(b ? "done_cycle_b" : "done_cycle_a", cyc, e.done_cyc);
        check(b ? "done_busy_b" : "done_busy_a", b ? busy_b : busy_a, 0);
        check(b ? "rises_b" : "rises_a", b ? rises_b - rise0_b : rises_a - rise0_a, N * P);
        check(b ? "chain_b" : "chain_a", b ? chain_b : chain_a, e.word);
        check(b ? "readback_b" : "readback_a", b ? readback_b : readback_a, e.rb);
        check(b ? "mismatch_b" : "mismatch_a", b ? mismatch_b : mismatch_a, e.mm);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed time-out expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    // Reset and idle.
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_sr_clk", sr_clk_a, 0);
    end
    check("idle_busy", {busy_a, busy_b}, 0);
    check("idle_done", {done_a, done_b}, 0);
    check("idle_mismatch", {mismatch_a, mismatch_b}, 0);
    check("idle_readback_a", readback_a, 0);
    check("idle_readback_b", readback_b, 0);
    check("idle_sr_data", {sr_data_a, sr_data_b}, 0);
    check("idle_rises", rises_a + rises_b, 0);

    // Plain programming.
    do_start(1'b0, 34'h2_AAAA_5555);
    wait_done(1'b0);

    // Stuck chain output.
    repeat (3) @(negedge clk);
    stuck = 1'b1;
    do_start(1'b0, 34'h3_FFFF_FFFF);
    wait_done(1'b0);
    repeat (6) @(negedge clk);
    check("mismatch_hold", mismatch_a, RB);
    stuck = 1'b0;

    // Second start while busy is ignored.
    cnt0 = done_cnt_a;
    do_start(1'b0, 34'h0_1234_ABCD);
    repeat (49) @(negedge clk);
    cfg_a   = 34'h1_5A5A_0F0F;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0);
    repeat (5) @(negedge clk);
    check("single_done", done_cnt_a - cnt0, 1);

    // Reset mid-sequence, then reprogram.
    cnt0 = done_cnt_a;
    do_start(1'b0, 34'h3_FFFF_FFFF);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_sr_clk", sr_clk_a, 0);
    check("rst_sr_data", sr_data_a, 0);
    check("rst_done", done_a, 0);
    check("rst_readback", readback_a, 0);
    sb_a.delete();
    sb_b.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    check("rst_no_done", done_cnt_a - cnt0, 0);
    do_start(1'b0, 34'h1_0F0F_F0F0);
    wait_done(1'b0);

    // Slower divider on instance B.
    do_start(1'b1, 34'h1_2345_6789);
    wait_done(1'b1);
    repeat (5) @(negedge clk);
    check("done_cnt_b", done_cnt_b, 1);

    check("sr_data_stable_a", viol_a, 0);
    check("sr_data_stable_b", viol_b, 0);
    check("sb_empty", sb_a.size() + sb_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
